// File: rtl/mult_fu.sv
// mult_fu: pipelined RV32M MUL/MULH/MULHSU/MULHU unit from the RS multiply issue port to the CDB.
// Latency: MULT_STAGES cycles from issue to cdb_req, plus one cycle per denied grant.
// Backpressure: elastic stages hold on denied grant; avail reserves a slot conservatively.
// Optional feature: define MULT_SQUASH_EN to add a squash port that flushes all in-flight ops.

package mult_fu_pkg;

    localparam int PRN_WIDTH     = 6;
    localparam int ROB_CNT_WIDTH = 5;

    // RV32M funct3 encodings; anything else is executed as MUL.
    localparam logic [2:0] FUNC_MUL    = 3'b000;
    localparam logic [2:0] FUNC_MULH   = 3'b001;
    localparam logic [2:0] FUNC_MULHSU = 3'b010;
    localparam logic [2:0] FUNC_MULHU  = 3'b011;

    typedef struct packed {
        logic                     valid;
        logic [2:0]               func;
        logic [31:0]              op1;
        logic [31:0]              op2;
        logic [PRN_WIDTH-1:0]     dest_prn;
        logic [ROB_CNT_WIDTH-1:0] robn;
    } FU_PACKET;

    typedef struct packed {
        logic [PRN_WIDTH-1:0] dest_prn;
        logic [31:0]          value;
    } CDB_PACKET;

endpackage

module mult_fu
    import mult_fu_pkg::*;
#(
    // Legal depths: 1, 2, 4, 8 (must divide the 32-bit multiplier evenly).
    parameter int MULT_STAGES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  FU_PACKET                 fu_packet,
    output logic                     avail,
    output logic                     cdb_req,
    input  logic                     cdb_gnt,
    output CDB_PACKET                cdb_out,
    output logic [ROB_CNT_WIDTH-1:0] cdb_robn
`ifdef MULT_SQUASH_EN
    ,
    input  logic                     squash
`endif
);

    localparam int LAST  = MULT_STAGES - 1;
    localparam int CHUNK = 32 / MULT_STAGES;
    localparam int CW    = $clog2(MULT_STAGES + 1);

    // One pipeline slot: the op travels with its operands and running sum.
    typedef struct packed {
        logic                     vld;
        logic [2:0]               func;
        logic [PRN_WIDTH-1:0]     prn;
        logic [ROB_CNT_WIDTH-1:0] robn;
        logic [32:0]              mcand;
        logic [32:0]              mplier;
        logic [63:0]              acc;
    } stage_t;

    stage_t                 stg_q [MULT_STAGES];
    stage_t                 stg_d [MULT_STAGES];
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic [MULT_STAGES-1:0] adv;
    logic                   drain;
    logic                   stage0_free;
    logic                   accept;
    logic                   drop;
    logic                   kill;
    logic [32:0]            in_mcand;
    logic [32:0]            in_mplier;

    // 33-bit operand: the extra top bit is either a copy of bit 31 or zero.
    function automatic logic [32:0] extend(input logic [31:0] x, input logic sgn);
        return {sgn & x[31], x};
    endfunction

    // Partial product of multiplier chunk k, already shifted into place.
    // Lower chunks are unsigned slices; the top chunk keeps the sign so the
    // chunk values sum exactly to the signed 33-bit multiplier.
    function automatic logic [63:0] partial(input logic [32:0] a, input logic [32:0] b,
                                            input int k);
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] chunk;
        a64 = {{31{a[32]}}, a};
        b64 = {{31{b[32]}}, b};
        if (k == LAST) begin
            chunk = 64'($signed(b64) >>> (k * CHUNK));
        end else begin
            chunk = (b64 >> (k * CHUNK)) & ((64'd1 << CHUNK) - 64'd1);
        end
        return (a64 * chunk) << (k * CHUNK);
    endfunction

`ifdef MULT_SQUASH_EN
    assign kill = squash;
`else
    assign kill = 1'b0;
`endif

    // Operand extension by opcode: MULHU unsigned both, MULHSU unsigned op2.
    always_comb begin
        in_mcand  = extend(fu_packet.op1, fu_packet.func != FUNC_MULHU);
        in_mplier = extend(fu_packet.op2, (fu_packet.func != FUNC_MULHSU) &&
                                          (fu_packet.func != FUNC_MULHU));
    end

    // Elastic advance chain, resolved from the CDB end back to stage 0.
    always_comb begin
        adv       = '0;
        drain     = stg_q[LAST].vld & cdb_gnt;
        adv[LAST] = drain;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = stg_q[k].vld & (~stg_q[k+1].vld | adv[k+1]);
        end
        stage0_free = ~stg_q[0].vld | adv[0];
        accept      = fu_packet.valid & stage0_free & ~kill;
        drop        = fu_packet.valid & ~stage0_free & ~kill;
    end

    // Next stage contents and occupancy; squash wipes everything in flight.
    always_comb begin
        for (int k = 0; k < MULT_STAGES; k++) begin
            stg_d[k] = stg_q[k];
        end

        if (accept) begin
            stg_d[0].vld    = 1'b1;
            stg_d[0].func   = fu_packet.func;
            stg_d[0].prn    = fu_packet.dest_prn;
            stg_d[0].robn   = fu_packet.robn;
            stg_d[0].mcand  = in_mcand;
            stg_d[0].mplier = in_mplier;
            stg_d[0].acc    = partial(in_mcand, in_mplier, 0);
        end else if (adv[0]) begin
            stg_d[0].vld = 1'b0;
        end

        for (int k = 1; k < MULT_STAGES; k++) begin
            if (adv[k-1]) begin
                stg_d[k]     = stg_q[k-1];
                stg_d[k].acc = stg_q[k-1].acc +
                               partial(stg_q[k-1].mcand, stg_q[k-1].mplier, k);
            end else if (adv[k]) begin
                stg_d[k].vld = 1'b0;
            end
        end

        count_d = count_q + CW'(accept) - CW'(drain);

        if (kill) begin
            for (int k = 0; k < MULT_STAGES; k++) begin
                stg_d[k].vld = 1'b0;
            end
            count_d = '0;
        end
    end

    // Stage and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < MULT_STAGES; k++) begin
                stg_q[k] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int k = 0; k < MULT_STAGES; k++) begin
                stg_q[k] <= stg_d[k];
            end
            count_q <= count_d;
        end
    end

    // An issue while stage 0 is held means the RS ignored avail; the packet is lost.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!drop)
                else $error("mult_fu: packet robn %0d dropped, stage 0 stalled", fu_packet.robn);
        end
    end

    // avail counts the packet on the wire now, so the next cycle always has a slot.
    always_comb begin
        avail   = ({1'b0, count_q} + (CW+1)'(fu_packet.valid)) < (CW+1)'(MULT_STAGES);
        cdb_req = stg_q[LAST].vld;
        cdb_out.dest_prn = cdb_req ? stg_q[LAST].prn : '0;
        case (stg_q[LAST].func)
            FUNC_MULH, FUNC_MULHSU, FUNC_MULHU: cdb_out.value = stg_q[LAST].acc[63:32];
            default:                            cdb_out.value = stg_q[LAST].acc[31:0];
        endcase
        cdb_robn = stg_q[LAST].robn;
    end

endmodule
